// File: rtl/piano_keyboard_overlay.sv
`default_nettype none
// ============================================================================
// Module      : piano_keyboard_overlay (with helper piano_key_timer)
// Description : Draws a NUM_WHITE-key piano over the camera pixel stream and
//               recolours keys that were requested within the last HOLD_FRAMES
//               frames. Optional macro KEY_FADE_EN fades lit colours with age.
// Revision    : 1.0 - initial release
// ============================================================================

module piano_key_timer #(
    parameter int HOLD_FRAMES = 15
`ifdef KEY_FADE_EN
    ,
    parameter int MUL0 = 0,
    parameter int MUL1 = 0
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_start,
    input  logic       req,
    output logic       lit
`ifdef KEY_FADE_EN
    ,
    output logic [3:0] scale0,
    output logic [3:0] scale1
`endif
);
    localparam int C_W = $clog2(HOLD_FRAMES + 1);

    logic [C_W-1:0] r_cnt;
    logic [C_W-1:0] w_cnt_nxt;
    logic           r_seen;

    always_comb begin
        if (r_seen || req) begin
            w_cnt_nxt = C_W'(HOLD_FRAMES);
        end else if (r_cnt != '0) begin
            w_cnt_nxt = r_cnt - C_W'(1);
        end else begin
            w_cnt_nxt = r_cnt;
        end
    end

`ifdef KEY_FADE_EN
    function automatic logic [3:0] scaled(input int mul, input logic [C_W-1:0] c);
        return 4'((mul * int'(c)) / HOLD_FRAMES);
    endfunction
`endif

    // Counter and lit flag only move on frame_start so a key never tears mid-frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt  <= '0;
            r_seen <= 1'b0;
            lit    <= 1'b0;
`ifdef KEY_FADE_EN
            scale0 <= 4'd0;
            scale1 <= 4'd0;
`endif
        end else if (frame_start) begin
            r_cnt  <= w_cnt_nxt;
            r_seen <= 1'b0;
            lit    <= (w_cnt_nxt != '0);
`ifdef KEY_FADE_EN
            scale0 <= scaled(MUL0, w_cnt_nxt);
            scale1 <= scaled(MUL1, w_cnt_nxt);
`endif
        end else if (req) begin
            r_seen <= 1'b1;
        end
    end
endmodule

module piano_keyboard_overlay #(
    parameter int NUM_WHITE      = 8,
    parameter int KEY_W          = 70,
    parameter int BLACK_W        = 48,
    parameter int X_START        = 40,
    parameter int Y_TOP          = 250,
    parameter int Y_BOTTOM       = 479,
    parameter int BLACK_Y_BOTTOM = 370,
    parameter int HOLD_FRAMES    = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 de,
    input  logic [9:0]           x,
    input  logic [9:0]           y,
    input  logic [3:0]           cam_r,
    input  logic [3:0]           cam_g,
    input  logic [3:0]           cam_b,
    input  logic                 frame_start,
    input  logic [NUM_WHITE-1:0] white_on,
    input  logic [NUM_WHITE-2:0] black_on,
    output logic [3:0]           out_r,
    output logic [3:0]           out_g,
    output logic [3:0]           out_b,
    output logic                 de_out,
    output logic [NUM_WHITE-1:0] white_lit,
    output logic [NUM_WHITE-2:0] black_lit
);
    localparam int          C_IW     = $clog2(NUM_WHITE);
    localparam logic [11:0] C_X_LO   = 12'(X_START);
    localparam logic [11:0] C_X_END  = 12'(X_START + NUM_WHITE * KEY_W);
    localparam logic [11:0] C_X_LAST = 12'(X_START + NUM_WHITE * KEY_W - 1);

    logic [11:0]          w_xw;
    logic [11:0]          w_yw;
    logic                 w_in_band;
    logic                 w_in_black_rows;
    logic [NUM_WHITE-1:0] w_hit_w;
    logic [NUM_WHITE-1:0] w_edge_w;
    logic [NUM_WHITE-2:0] w_hit_b;
    logic [C_IW-1:0]      w_widx;
    logic [C_IW-1:0]      w_bidx;

`ifdef KEY_FADE_EN
    logic [3:0] w_wsc0 [NUM_WHITE];
    logic [3:0] w_wsc1 [NUM_WHITE];
    logic [3:0] w_bsc0 [NUM_WHITE-1];
    logic [3:0] w_bsc1 [NUM_WHITE-1];
`endif

    assign w_xw            = {2'b00, x};
    assign w_yw            = {2'b00, y};
    assign w_in_band       = (w_yw >= 12'(Y_TOP)) && (w_yw <= 12'(Y_BOTTOM));
    assign w_in_black_rows = (w_yw >= 12'(Y_TOP)) && (w_yw <= 12'(BLACK_Y_BOTTOM));

    genvar i;
    generate
        for (i = 0; i < NUM_WHITE; i++) begin : g_white
            localparam logic [11:0] C_L = 12'(X_START + i * KEY_W);
            localparam logic [11:0] C_R = 12'(X_START + (i + 1) * KEY_W - 1);

            assign w_hit_w[i]  = (w_xw >= C_L) && (w_xw <= C_R);
            assign w_edge_w[i] = (w_xw == C_L);

            piano_key_timer #(
                .HOLD_FRAMES (HOLD_FRAMES)
`ifdef KEY_FADE_EN
                ,
                .MUL0        (5),
                .MUL1        (15)
`endif
            ) u_timer (
                .clk         (clk),
                .reset       (reset),
                .frame_start (frame_start),
                .req         (white_on[i]),
                .lit         (white_lit[i])
`ifdef KEY_FADE_EN
                ,
                .scale0      (w_wsc0[i]),
                .scale1      (w_wsc1[i])
`endif
            );
        end

        for (i = 0; i < NUM_WHITE - 1; i++) begin : g_black
            // Slots after E (i%7==2) and B (i%7==6) have no black key in a C-based octave.
            localparam bit          C_EXISTS = ((i % 7) != 2) && ((i % 7) != 6);
            localparam int          C_B      = X_START + (i + 1) * KEY_W;
            localparam logic [11:0] C_L      = 12'(C_B - BLACK_W / 2);
            localparam logic [11:0] C_R      = 12'(C_B + BLACK_W / 2 - 1);

            assign w_hit_b[i] = C_EXISTS && w_in_black_rows && (w_xw >= C_L) && (w_xw <= C_R);

            piano_key_timer #(
                .HOLD_FRAMES (HOLD_FRAMES)
`ifdef KEY_FADE_EN
                ,
                .MUL0        (10),
                .MUL1        (6)
`endif
            ) u_timer (
                .clk         (clk),
                .reset       (reset),
                .frame_start (frame_start),
                .req         (black_on[i] && C_EXISTS),
                .lit         (black_lit[i])
`ifdef KEY_FADE_EN
                ,
                .scale0      (w_bsc0[i]),
                .scale1      (w_bsc1[i])
`endif
            );
        end
    endgenerate

    always_comb begin
        w_widx = '0;
        for (int k = 0; k < NUM_WHITE; k++) begin
            if (w_hit_w[k]) w_widx = C_IW'(k);
        end
        w_bidx = '0;
        for (int k = 0; k < NUM_WHITE - 1; k++) begin
            if (w_hit_b[k]) w_bidx = C_IW'(k);
        end
    end

    logic            r_s1_de;
    logic [11:0]     r_s1_cam;
    logic            r_s1_black;
    logic            r_s1_outline;
    logic            r_s1_white;
    logic            r_s1_outside;
    logic [C_IW-1:0] r_s1_widx;
    logic [C_IW-1:0] r_s1_bidx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_de      <= 1'b0;
            r_s1_cam     <= '0;
            r_s1_black   <= 1'b0;
            r_s1_outline <= 1'b0;
            r_s1_white   <= 1'b0;
            r_s1_outside <= 1'b0;
            r_s1_widx    <= '0;
            r_s1_bidx    <= '0;
        end else begin
            r_s1_de      <= de;
            r_s1_cam     <= {cam_r, cam_g, cam_b};
            r_s1_black   <= |w_hit_b;
            r_s1_outline <= w_in_band && ((|w_edge_w) || (w_xw == C_X_LAST));
            r_s1_white   <= w_in_band && (|w_hit_w);
            r_s1_outside <= w_in_band && ((w_xw < C_X_LO) || (w_xw >= C_X_END));
            r_s1_widx    <= w_widx;
            r_s1_bidx    <= w_bidx;
        end
    end

    logic [11:0] w_white_lit_col;
    logic [11:0] w_black_lit_col;
    logic [11:0] w_col;

`ifdef KEY_FADE_EN
    assign w_white_lit_col = {4'd15, 4'd15 - w_wsc0[r_s1_widx], 4'd15 - w_wsc1[r_s1_widx]};
    assign w_black_lit_col = {w_bsc0[r_s1_bidx], w_bsc1[r_s1_bidx], 4'd0};
`else
    assign w_white_lit_col = 12'hFA0;
    assign w_black_lit_col = 12'hA60;
`endif

    always_comb begin
        w_col = r_s1_cam;
        if (!r_s1_de) begin
            w_col = 12'h000;
        end else if (r_s1_black) begin
            w_col = black_lit[r_s1_bidx] ? w_black_lit_col : 12'h000;
        end else if (r_s1_outline) begin
            w_col = 12'h000;
        end else if (r_s1_white) begin
            w_col = white_lit[r_s1_widx] ? w_white_lit_col : 12'hFFF;
        end else if (r_s1_outside) begin
            w_col = 12'h222;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_r  <= 4'd0;
            out_g  <= 4'd0;
            out_b  <= 4'd0;
            de_out <= 1'b0;
        end else begin
            out_r  <= w_col[11:8];
            out_g  <= w_col[7:4];
            out_b  <= w_col[3:0];
            de_out <= r_s1_de;
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_piano_keyboard_overlay.sv
`default_nettype none
// ============================================================================
// Module      : tb_piano_keyboard_overlay
// Description : Scoreboard bench for piano_keyboard_overlay; a driver pushes
//               model predictions, a monitor pops and compares them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_piano_keyboard_overlay;
    localparam int N   = 8;
    localparam int KW  = 70;
    localparam int BW  = 48;
    localparam int X0  = 40;
    localparam int YT  = 250;
    localparam int YB  = 479;
    localparam int BYB = 370;
    localparam int H   = 15;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         de = 1'b0;
    logic [9:0]   x = '0;
    logic [9:0]   y = '0;
    logic [3:0]   cam_r = '0;
    logic [3:0]   cam_g = '0;
    logic [3:0]   cam_b = '0;
    logic         frame_start = 1'b0;
    logic [N-1:0] white_on = '0;
    logic [N-2:0] black_on = '0;
    logic [3:0]   out_r;
    logic [3:0]   out_g;
    logic [3:0]   out_b;
    logic         de_out;
    logic [N-1:0] white_lit;
    logic [N-2:0] black_lit;

    always #5 clk = ~clk;

    piano_keyboard_overlay #(
        .NUM_WHITE(N), .KEY_W(KW), .BLACK_W(BW), .X_START(X0),
        .Y_TOP(YT), .Y_BOTTOM(YB), .BLACK_Y_BOTTOM(BYB), .HOLD_FRAMES(H)
    ) dut (
        .clk(clk), .reset(reset), .de(de), .x(x), .y(y),
        .cam_r(cam_r), .cam_g(cam_g), .cam_b(cam_b),
        .frame_start(frame_start), .white_on(white_on), .black_on(black_on),
        .out_r(out_r), .out_g(out_g), .out_b(out_b), .de_out(de_out),
        .white_lit(white_lit), .black_lit(black_lit)
    );

    typedef struct { int due; logic [12:0] val; } pix_t;
    typedef struct { int due; logic [N-1:0] w; logic [N-2:0] b; } lit_t;

    pix_t pq[$];
    lit_t lq[$];
    int   cyc   = 0;
    int   tests = 0;
    int   fails = 0;

    // Reference state: frames remaining per key and a "requested this frame" flag.
    int wcnt[N];
    int bcnt[N-1];
    bit wseen[N];
    bit bseen[N-1];
    bit prev_rst = 1'b1;

    function automatic bit slot_exists(input int s);
        return (s % 7 != 2) && (s % 7 != 6);
    endfunction

    function automatic logic [11:0] white_col(input int c);
        if (c == 0) return 12'hFFF;
`ifdef KEY_FADE_EN
        return {4'd15, 4'(15 - (5 * c) / H), 4'(15 - (15 * c) / H)};
`else
        return 12'hFA0;
`endif
    endfunction

    function automatic logic [11:0] black_col(input int c);
        if (c == 0) return 12'h000;
`ifdef KEY_FADE_EN
        return {4'((10 * c) / H), 4'((6 * c) / H), 4'd0};
`else
        return 12'hA60;
`endif
    endfunction

    function automatic logic [12:0] exp_pix(input bit dd, input int xx, input int yy, input logic [11:0] cam);
        int xend;
        int b;
        xend = X0 + N * KW;
        if (!dd) return 13'd0;
        if (yy >= YT && yy <= BYB) begin
            for (int s = 0; s < N - 1; s++) begin
                b = X0 + (s + 1) * KW;
                if (slot_exists(s) && xx >= b - BW / 2 && xx <= b + BW / 2 - 1)
                    return {1'b1, black_col(bcnt[s])};
            end
        end
        if (yy >= YT && yy <= YB) begin
            if (xx >= X0 && xx < xend) begin
                if ((xx - X0) % KW == 0 || xx == xend - 1) return {1'b1, 12'h000};
                return {1'b1, white_col(wcnt[(xx - X0) / KW])};
            end
            return {1'b1, 12'h222};
        end
        return {1'b1, cam};
    endfunction

    function automatic void update_model(input bit fs, input logic [N-1:0] wo, input logic [N-2:0] bo);
        for (int i = 0; i < N; i++) begin
            if (fs) begin
                if (wseen[i] || wo[i]) wcnt[i] = H;
                else if (wcnt[i] > 0) wcnt[i] = wcnt[i] - 1;
                wseen[i] = 1'b0;
            end else if (wo[i]) begin
                wseen[i] = 1'b1;
            end
        end
        for (int s = 0; s < N - 1; s++) begin
            if (!slot_exists(s)) continue;
            if (fs) begin
                if (bseen[s] || bo[s]) bcnt[s] = H;
                else if (bcnt[s] > 0) bcnt[s] = bcnt[s] - 1;
                bseen[s] = 1'b0;
            end else if (bo[s]) begin
                bseen[s] = 1'b1;
            end
        end
    endfunction

    task automatic step(input bit rs, input bit fs, input bit dd, input int xx, input int yy,
                        input logic [N-1:0] wo, input logic [N-2:0] bo);
        pix_t        pe;
        lit_t        le;
        logic [11:0] cam;
        @(negedge clk);
        cam         = 12'($urandom);
        reset       = rs;
        frame_start = fs;
        de          = dd;
        x           = 10'(xx);
        y           = 10'(yy);
        {cam_r, cam_g, cam_b} = cam;
        white_on    = wo;
        black_on    = bo;
        if (rs) begin
            if (!prev_rst) begin
                pq.delete();
                lq.delete();
            end
            for (int i = 0; i < N; i++) begin wcnt[i] = 0; wseen[i] = 1'b0; end
            for (int s = 0; s < N - 1; s++) begin bcnt[s] = 0; bseen[s] = 1'b0; end
            pe.val = 13'd0;
        end else begin
            update_model(fs, wo, bo);
            pe.val = exp_pix(dd, xx, yy, cam);
        end
        pe.due = cyc + 2;
        pq.push_back(pe);
        le.due = cyc + 1;
        for (int i = 0; i < N; i++) le.w[i] = (wcnt[i] != 0);
        for (int s = 0; s < N - 1; s++) le.b[s] = (bcnt[s] != 0);
        lq.push_back(le);
        prev_rst = rs;
    endtask

    task automatic rand_step(input bit rs, input bit fs, input logic [N-1:0] wo, input logic [N-2:0] bo);
        int xx;
        int yy;
        if ($urandom_range(0, 7) == 0) begin
            xx = 200;
            yy = 400;
        end else begin
            xx = $urandom_range(0, 639);
            yy = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 479) : $urandom_range(240, 479);
        end
        step(rs, fs, ($urandom_range(0, 9) != 0), xx, yy, wo, bo);
    endtask

    task automatic run_frames(input int nf, input int flen, input logic [N-1:0] wheld,
                              input logic [N-2:0] bheld, input bit rnd);
        logic [N-1:0] wr;
        logic [N-2:0] br;
        for (int f = 0; f < nf; f++) begin
            for (int c = 0; c < flen; c++) begin
                wr = '0;
                br = '0;
                if (rnd) begin
                    for (int i = 0; i < N; i++) wr[i] = ($urandom_range(0, 399) == 0);
                    for (int s = 0; s < N - 1; s++) br[s] = ($urandom_range(0, 399) == 0);
                end
                rand_step(1'b0, (c == 0), wheld | wr, bheld | br);
            end
        end
    endtask

    initial begin : monitor
        pix_t pe;
        lit_t le;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            while (pq.size() > 0 && pq[0].due <= cyc) begin
                pe = pq.pop_front();
                tests++;
                if (pe.due != cyc || {de_out, out_r, out_g, out_b} !== pe.val) begin
                    fails++;
                    $display("FAIL pixel cyc=%0d got de=%0b rgb=%h expected de=%0b rgb=%h (due %0d)",
                             cyc, de_out, {out_r, out_g, out_b}, pe.val[12], pe.val[11:0], pe.due);
                end
            end
            while (lq.size() > 0 && lq[0].due <= cyc) begin
                le = lq.pop_front();
                tests++;
                if (le.due != cyc || white_lit !== le.w || black_lit !== le.b) begin
                    fails++;
                    $display("FAIL lit cyc=%0d got white=%b black=%b expected white=%b black=%b",
                             cyc, white_lit, black_lit, le.w, le.b);
                end
            end
        end
    end

    initial begin : driver
        repeat (3) step(1'b1, 1'b0, 1'b1, 100, 300, '0, '0);
        repeat (4) step(1'b0, 1'b0, 1'b1, 100, 300, '0, '0);
        for (int xx = 0; xx < 640; xx++) step(1'b0, 1'b0, 1'b1, xx, 300, '0, '0);

        // One-cycle request mid-frame, then watch it hold and expire.
        run_frames(1, 20, '0, '0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 200, 400, N'(4), '0);
        run_frames(17, 20, '0, '0, 1'b0);

        // Request held on the absent E-F black slot.
        run_frames(3, 20, '0, (N-1)'(4), 1'b0);
        step(1'b0, 1'b0, 1'b1, 250, 300, '0, '0);

        // Request coincident with frame_start, then a retrigger at count 3.
        step(1'b0, 1'b1, 1'b1, 60, 400, N'(1), '0);
        for (int c = 1; c < 20; c++) rand_step(1'b0, 1'b0, '0, '0);
        run_frames(12, 20, '0, '0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 60, 400, N'(1), '0);
        run_frames(3, 20, '0, '0, 1'b0);

        run_frames(60, 20, '0, '0, 1'b1);
        for (int c = 0; c < 7; c++) rand_step(1'b0, 1'b0, '1, '1);
        repeat (2) rand_step(1'b1, 1'b0, '0, '0);
        run_frames(40, 20, '0, '0, 1'b1);

        repeat (4) @(negedge clk);
        tests++;
        if (pq.size() != 0 || lq.size() != 0) begin
            fails++;
            $display("FAIL drain got %0d pixel and %0d lit entries pending, required 0", pq.size(), lq.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire
